// File: rtl/yarp_pkg.sv
// Shared widths and the writeback grant-select encoding for the yarp pipeline.
package yarp_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_EX,
        WB_MEM
    } wb_src_t;

endpackage

// File: rtl/yarp_wb_arbiter.sv
// Writeback arbiter: merges EX and load results onto the single register-file write port.
// MEM wins conflicts unless EX has lost STARVE_LIMIT cycles in a row; results land one cycle after grant.
module yarp_wb_arbiter
    import yarp_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [XLEN-1:0]   ex_data_i,
    output logic              ex_ready_o,
    input  logic              mem_valid_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [XLEN-1:0]   mem_data_i,
    output logic              mem_ready_o,
    input  logic              flush_i,
    output logic              wr_en_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic [XLEN-1:0]   wr_data_o
);

    localparam logic [2:0] LIMIT = STARVE_LIMIT[2:0];

    wb_src_t           w_sel;
    logic [REG_AW-1:0] w_rd;
    logic [XLEN-1:0]   w_data;
    logic [2:0]        r_ex_wait_cnt;
    logic              r_wr_en;
    logic [REG_AW-1:0] r_rd_addr;
    logic [XLEN-1:0]   r_wr_data;

    // Grants are held off during reset and flush so nothing is accepted in those cycles.
    always_comb begin
        w_sel = WB_NONE;
        if (!reset && !flush_i) begin
            if (ex_valid_i && mem_valid_i) begin
                w_sel = (r_ex_wait_cnt == LIMIT) ? WB_EX : WB_MEM;
            end else if (ex_valid_i) begin
                w_sel = WB_EX;
            end else if (mem_valid_i) begin
                w_sel = WB_MEM;
            end
        end
    end

    always_comb begin
        w_rd   = ex_rd_i;
        w_data = ex_data_i;
        if (w_sel == WB_MEM) begin
            w_rd   = mem_rd_i;
            w_data = mem_data_i;
        end
    end

    assign ex_ready_o  = (w_sel == WB_EX);
    assign mem_ready_o = (w_sel == WB_MEM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_wait_cnt <= 3'd0;
        end else if (flush_i || !ex_valid_i || (w_sel == WB_EX)) begin
            r_ex_wait_cnt <= 3'd0;
        end else if (r_ex_wait_cnt < LIMIT) begin
            r_ex_wait_cnt <= r_ex_wait_cnt + 3'd1;
        end
    end

    // Writes to x0 complete the handshake but leave the visible address/data untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= (w_sel != WB_NONE) && (w_rd != '0);
            if ((w_sel != WB_NONE) && (w_rd != '0)) begin
                r_rd_addr <= w_rd;
                r_wr_data <= w_data;
            end
        end
    end

    assign wr_en_o   = r_wr_en;
    assign rd_addr_o = r_rd_addr;
    assign wr_data_o = r_wr_data;

endmodule

// File: doc/yarp_wb_arbiter.md
YARP_WB_ARBITER -- requirements
Module: yarp_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: number of consecutive losing cycles after which EX wins a conflict (legal range 1..7).
REQ-002 Port list, in order:
- clk  input  1  sole clock
- reset  input  1  synchronous, active-high reset
- ex_valid_i  input  1  EX writeback request
- ex_rd_i  input  5  EX destination register
- ex_data_i  input  32  EX result
- ex_ready_o  output  1  EX request accepted this cycle
- mem_valid_i  input  1  load writeback request
- mem_rd_i  input  5  load destination register
- mem_data_i  input  32  load data
- mem_ready_o  output  1  load request accepted this cycle
- flush_i  input  1  pipeline flush; blocks acceptance this cycle
- wr_en_o  output  1  register file write enable
- rd_addr_o  output  5  register file write address
- wr_data_o  output  32  register file write data
REQ-003 Single clock domain: clk, with synchronous active-high reset.

Function
REQ-010 ex_ready_o and mem_ready_o SHALL be combinational grants; a transfer occurs when valid and ready are both 1 in the same cycle.
REQ-011 At most one ready SHALL be 1 in any cycle.
REQ-012 Only one source valid (flush_i=0): that source SHALL be granted.
REQ-013 Both valid (flush_i=0): MEM granted, unless ex_wait_cnt == STARVE_LIMIT, then EX granted.
REQ-014 ex_wait_cnt is a 3-bit counter; per cycle it SHALL:
- increment, saturating at STARVE_LIMIT, when ex_valid_i=1 and EX is not granted;
- clear when EX is granted, when ex_valid_i=0, or when flush_i=1.
REQ-015 flush_i=1: both readys SHALL be 0 and nothing accepted that cycle; a write already on the outputs is not cancelled.
REQ-016 Output latency of 1 cycle: an accepted transfer in cycle N SHALL drive wr_en_o, rd_addr_o, wr_data_o in cycle N+1 from registered copies of the granted rd and data.
REQ-017 An accepted transfer with rd == 0 SHALL complete the handshake, but wr_en_o SHALL be 0 in cycle N+1 (x0 hardwired).
REQ-018 When no transfer is accepted in cycle N, wr_en_o SHALL be 0 in N+1, and rd_addr_o and wr_data_o SHALL hold their previous values.
REQ-019 Both sources target the same rd: writes SHALL be issued in grant order (MEM first, EX next), so the later grant's value persists.
REQ-020 Requesters SHALL hold valid, rd and data stable until accepted; the arbiter does not buffer unaccepted requests.
REQ-021 Sustained throughput SHALL be one write per cycle with no bubbles while any source is valid and flush_i=0.

Reset
REQ-030 While reset=1 at a clk edge: wr_en_o=0, rd_addr_o=0, wr_data_o=0, ex_wait_cnt=0.
REQ-031 While reset=1, ex_ready_o and mem_ready_o SHALL be 0.
REQ-032 Reset asserted mid-stream SHALL drop any pending write: wr_en_o=0 in the following cycle.
REQ-033 The first grant SHALL be possible in the first cycle with reset=0.

Structure
REQ-040 yarp_pkg SHALL hold:
- XLEN=32 and REG_AW=5;
- enum wb_src_t {WB_NONE, WB_EX, WB_MEM}, used for the internal grant select.
REQ-041 No sub-module: grant logic, counter and output register are all in yarp_wb_arbiter; the parent connects wr_en_o, rd_addr_o and wr_data_o to the register file write port.

Verification
REQ-050 The bench SHALL cover these directed scenarios:
- EX only, rd=5, data=0xDEADBEEF -> ex_ready_o=1 same cycle; next cycle wr_en_o=1, rd_addr_o=5, wr_data_o=0xDEADBEEF.
- Both valid every cycle, STARVE_LIMIT=3 -> MEM granted 3 cycles, EX in cycle 4, counter cleared, MEM next.
- MEM rd=0, data=0x1234 -> mem_ready_o=1; next cycle wr_en_o=0; rd_addr_o and wr_data_o unchanged.
- Both valid, same rd=7, EX=0xA, MEM=0xB -> wr_data_o 0xB then 0xA on consecutive cycles.
- flush_i=1 with both valid -> both readys 0, wr_en_o=0 next cycle, counter 0; earlier accepted write still appears.
- reset=1 during back-to-back writes -> outputs 0 next edge, readys 0 while reset high, grants resume the cycle after release.
